// File: rtl/joystick_event_queue_if.sv
// Bundle between the joystick event queue and its host.
// The host drives sample/joystick/rd/ovf_clr; the queue drives the rest.
interface joystick_event_queue_if #(
  parameter int PLAYERS = 6,
  parameter int BUTTONS = 32,
  parameter int DEPTH   = 16
);
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int BW = $clog2(BUTTONS);
  localparam int EW = 1 + PW + BW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                       sample;
  logic [PLAYERS*BUTTONS-1:0] joystick;
  logic                       rd;
  logic [EW-1:0]              rd_data;
  logic                       empty;
  logic                       full;
  logic [CW-1:0]              count;
  logic                       overflow;
  logic                       ovf_clr;
  logic                       busy;

  modport master (
    output sample, joystick, rd, ovf_clr,
    input  rd_data, empty, full, count, overflow, busy
  );

  modport slave (
    input  sample, joystick, rd, ovf_clr,
    output rd_data, empty, full, count, overflow, busy
  );
endinterface

// File: rtl/joystick_event_queue.sv
// Snapshots all joystick words on a strobe, scans one bit per cycle against the
// previous snapshot, and queues each change as {level, player, bit} in a FWFT FIFO.
module joystick_event_queue #(
  parameter int PLAYERS = 6,
  parameter int BUTTONS = 32,
  parameter int DEPTH   = 16
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  joystick_event_queue_if.slave bus
);
  localparam int N  = PLAYERS * BUTTONS;
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int BW = $clog2(BUTTONS);
  localparam int EW = 1 + PW + BW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(N);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [N-1:0]    r_cur;
  logic [N-1:0]    r_prev;

  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_empty;
  logic            r_full;
  logic            r_overflow;

  logic            w_last;
  logic            w_evt_valid;
  logic [EW-1:0]   w_event;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic [CW-1:0]   w_count_nxt;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = (r_idx == IW'(N - 1));
    w_evt_valid = 1'b0;
    w_event     = {r_cur[r_idx], PW'(r_idx >> BW), r_idx[BW-1:0]};
    case (r_state)
      S_IDLE: if (bus.sample) w_state_nxt = S_SCAN;
      S_SCAN: begin
        w_evt_valid = (r_cur[r_idx] != r_prev[r_idx]);
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A full FIFO still accepts an event when the same cycle pops the head.
  assign w_pop       = bus.rd && !r_empty;
  assign w_push      = w_evt_valid && (!r_full || bus.rd);
  assign w_drop      = w_evt_valid && !w_push;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cur   <= '0;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.sample) begin
            r_cur <= bus.joystick;
            r_idx <= '0;
          end
        end
        S_SCAN: begin
          r_prev[r_idx] <= r_cur[r_idx];
          r_idx         <= w_last ? '0 : r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (w_drop)           r_overflow <= 1'b1;
      else if (bus.ovf_clr) r_overflow <= 1'b0;
    end
  end

  // NOTE: storage is not reset; rd_data is masked to 0 while empty instead.
  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= w_event;
  end

  assign bus.rd_data  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.empty    = r_empty;
  assign bus.full     = r_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.busy     = (r_state == S_SCAN);
endmodule

// File: tb/tb_joystick_event_queue.sv
// Directed bench for joystick_event_queue with PLAYERS=2, BUTTONS=8, DEPTH=4.
module tb_joystick_event_queue;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  joystick_event_queue_if #(.PLAYERS(2), .BUTTONS(8), .DEPTH(4)) bus ();

  joystick_event_queue #(.PLAYERS(2), .BUTTONS(8), .DEPTH(4)) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop();
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  // Pulses sample and returns the number of busy cycles (capped at 100).
  task automatic run_scan(output int len);
    bus.sample = 1'b1;
    tick();
    bus.sample = 1'b0;
    len = 0;
    while (bus.busy && len < 100) begin
      len++;
      tick();
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.joystick = 16'hA5A5;
    apply_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.rd_data !== 5'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
    pop();
    checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL rd_when_empty count=%0d empty=%b exp count=0 empty=1", bus.count, bus.empty);
    end
  endtask

  task automatic test_basic();
    int len;
    bus.joystick = 16'h0005;
    run_scan(len);
    checks++; if (len !== 16) begin errors++; $display("FAIL basic_scan_len got=%0d exp=16", len); end
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL basic_count got=%0d exp=2", bus.count); end
    checks++; if (bus.rd_data !== 5'h10) begin errors++; $display("FAIL basic_head0 got=%h exp=10", bus.rd_data); end
    pop();
    checks++; if (bus.rd_data !== 5'h12) begin errors++; $display("FAIL basic_head1 got=%h exp=12", bus.rd_data); end
    pop();
    checks++; if (bus.empty !== 1'b1 || bus.rd_data !== 5'h00) begin
      errors++; $display("FAIL basic_drained empty=%b data=%h exp empty=1 data=00", bus.empty, bus.rd_data);
    end
  endtask

  task automatic test_release();
    int len;
    logic [4:0] exp_q [3];
    exp_q = '{5'h00, 5'h02, 5'h18};
    bus.joystick = 16'h0100;
    run_scan(len);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL release_count got=%0d exp=3", bus.count); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.rd_data !== exp_q[k]) begin
        errors++; $display("FAIL release_entry%0d got=%h exp=%h", k, bus.rd_data, exp_q[k]);
      end
      pop();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL release_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_overflow();
    int n;
    int len;
    apply_reset();
    bus.joystick = 16'h003F;
    bus.sample   = 1'b1;
    tick();
    bus.sample = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      // Index 5 is dropped; clearing in that same cycle must lose to the set.
      bus.ovf_clr = (n == 5);
      tick();
      if (n == 5) begin
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", bus.overflow); end
      end
      n++;
    end
    bus.ovf_clr = 1'b0;
    checks++; if (n !== 16) begin errors++; $display("FAIL ovf_scan_len got=%0d exp=16", n); end
    checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin
      errors++; $display("FAIL ovf_full count=%0d full=%b exp count=4 full=1", bus.count, bus.full);
    end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    checks++; if (bus.rd_data !== 5'h10) begin errors++; $display("FAIL ovf_head got=%h exp=10", bus.rd_data); end
    run_scan(len);
    checks++; if (bus.count !== 3'd4 || len !== 16) begin
      errors++; $display("FAIL ovf_rescan count=%0d len=%0d exp count=4 len=16", bus.count, len);
    end
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_full_pop();
    int n;
    logic [4:0] exp_q [4];
    exp_q = '{5'h12, 5'h13, 5'h16, 5'h17};
    bus.joystick = 16'h00FF;
    bus.sample   = 1'b1;
    tick();
    bus.sample = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      bus.rd = (n == 6 || n == 7);
      tick();
      n++;
    end
    bus.rd = 1'b0;
    checks++; if (n !== 16) begin errors++; $display("FAIL fullpop_scan_len got=%0d exp=16", n); end
    checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin
      errors++; $display("FAIL fullpop_count count=%0d full=%b exp count=4 full=1", bus.count, bus.full);
    end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got=%b exp=0", bus.overflow); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.rd_data !== exp_q[k]) begin
        errors++; $display("FAIL fullpop_entry%0d got=%h exp=%h", k, bus.rd_data, exp_q[k]);
      end
      pop();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fullpop_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_ignored_sample();
    int n;
    bus.joystick = 16'h00FD;
    bus.sample   = 1'b1;
    tick();
    bus.sample = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      bus.sample = (n == 3);
      if (n == 3) bus.joystick = 16'hFFFF;
      tick();
      n++;
    end
    bus.sample = 1'b0;
    checks++; if (n !== 16) begin errors++; $display("FAIL ignored_scan_len got=%0d exp=16", n); end
    tick();
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_no_rescan busy=%b exp=0", bus.busy); end
    checks++; if (bus.count !== 3'd1 || bus.rd_data !== 5'h01) begin
      errors++; $display("FAIL ignored_events count=%0d data=%h exp count=1 data=01", bus.count, bus.rd_data);
    end
  endtask

  task automatic test_mid_reset();
    int len;
    bus.joystick = 16'h0000;
    bus.sample   = 1'b1;
    tick();
    bus.sample = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checks++; if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
      errors++; $display("FAIL midrst_pre overflow=%b full=%b exp overflow=1 full=1", bus.overflow, bus.full);
    end
    reset_n = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
                  bus.overflow !== 1'b0 || bus.rd_data !== 5'h00) begin
      errors++; $display("FAIL midrst_outputs busy=%b count=%0d empty=%b full=%b ovf=%b data=%h exp 0/0/1/0/0/00",
                         bus.busy, bus.count, bus.empty, bus.full, bus.overflow, bus.rd_data);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    checks++; if (bus.busy !== 1'b0 || bus.count !== 3'd0) begin
      errors++; $display("FAIL midrst_aborted busy=%b count=%0d exp busy=0 count=0", bus.busy, bus.count);
    end
    bus.joystick = 16'h8000;
    run_scan(len);
    checks++; if (bus.count !== 3'd1 || bus.rd_data !== 5'h1F) begin
      errors++; $display("FAIL first_press count=%0d data=%h exp count=1 data=1f", bus.count, bus.rd_data);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset_n      = 1'b0;
    bus.sample   = 1'b0;
    bus.joystick = '0;
    bus.rd       = 1'b0;
    bus.ovf_clr  = 1'b0;
    test_reset();
    test_basic();
    test_release();
    test_overflow();
    test_full_pop();
    test_ignored_sample();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/joystick_event_queue.md
JOYSTICK_EVENT_QUEUE -- requirements
Module: joystick_event_queue

Interface
REQ-001 Parameter PLAYERS, default 6, number of joystick channels; range 1..8.
REQ-002 Parameter BUTTONS, default 32, bits per joystick word; power of 2, range 2..32.
REQ-003 Parameter DEPTH, default 16, event FIFO entries; power of 2, range 2..256.
REQ-004 Derived: PW = max(1, clog2(PLAYERS)), BW = clog2(BUTTONS), EW = 1+PW+BW, CW = clog2(DEPTH)+1.
REQ-005 clk_sys  in  1  single clock for all logic.
REQ-006 reset_n  in  1  reset, synchronous to clk_sys, active-low.
REQ-007 sample  in  1  one-cycle strobe that starts a snapshot (e.g. vblank edge).
REQ-008 joystick  in  PLAYERS*BUTTONS  packed joystick words; player p occupies bits [p*BUTTONS +: BUTTONS].
REQ-009 rd  in  1  pop head entry.
REQ-010 rd_data  out  EW  head entry {level, player[PW-1:0], bit[BW-1:0]}; 0 when empty.
REQ-011 empty  out  1  FIFO holds no entries.
REQ-012 full  out  1  FIFO holds DEPTH entries.
REQ-013 count  out  CW  entries held, 0..DEPTH.
REQ-014 overflow  out  1  sticky flag: at least one event dropped.
REQ-015 ovf_clr  in  1  clears overflow.
REQ-016 busy  out  1  scanner not in IDLE.

Function
REQ-017 The block SHALL hold a registered snapshot cur[PLAYERS*BUTTONS] and a previous-state register prev[PLAYERS*BUTTONS].
REQ-018 The scanner SHALL have two states: IDLE and SCAN.
REQ-019 In IDLE, sample=1 SHALL latch cur <= joystick, clear index i to 0, and enter SCAN the next cycle; busy=1 from that cycle.
REQ-020 In SCAN, the scanner SHALL examine one index i per cycle, in ascending order 0..PLAYERS*BUTTONS-1 (player-major, bit 0 first).
REQ-021 If cur[i] != prev[i], the scanner SHALL generate event {cur[i], i/BUTTONS, i%BUTTONS}.
REQ-022 The scanner SHALL set prev[i] <= cur[i] whether the event is pushed or dropped.
REQ-023 After index PLAYERS*BUTTONS-1 the scanner SHALL return to IDLE; a scan SHALL last exactly PLAYERS*BUTTONS cycles.
REQ-024 sample asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 Any change on joystick after latch SHALL NOT affect the scan in progress.
REQ-026 An event SHALL be pushed if full=0, or if full=1 and rd=1 in the same cycle (count unchanged).
REQ-027 Otherwise the event SHALL be dropped and overflow SHALL be set to 1 on the next edge.
REQ-028 When set and ovf_clr coincide, set SHALL win.
REQ-029 The FIFO SHALL be first-word fall-through: rd_data SHALL show the oldest entry whenever empty=0.
REQ-030 A pushed entry SHALL appear on rd_data one cycle after push if the FIFO was empty.
REQ-031 rd=1 while empty=1 SHALL be ignored: count stays 0 and no pointer moves.
REQ-032 Simultaneous push and pop with empty=0 SHALL leave count unchanged.
REQ-033 Read and write pointers SHALL wrap modulo DEPTH.
REQ-034 count, empty and full SHALL be registered and consistent with each other every cycle.

Reset
REQ-035 While reset_n=0 at a clk_sys edge, the block SHALL set: state=IDLE, busy=0, i=0, cur=0, prev=0, pointers=0, count=0, empty=1, full=0, overflow=0, rd_data=0.
REQ-036 Reset mid-scan SHALL abort the scan; no further events from that snapshot SHALL be pushed.
REQ-037 Buttons held at the first sample after reset SHALL produce press events (level=1), because prev resets to 0.

Verification (PLAYERS=2, BUTTONS=8, DEPTH=4; EW=5)
REQ-038 Basic events: joystick=16'h0005, pulse sample; expected: busy=1 for 16 cycles, then count=2 and rd_data=5'h10. After rd, rd_data=5'h12. After a second rd, empty=1.
REQ-039 Release and player field: after REQ-038, set joystick=16'h0100 and sample; expected events in order 5'h00 (p0 b0 release), 5'h02 (p0 b2 release), 5'h18 (p1 b0 press).
REQ-040 Overflow: joystick=16'h003F from reset, sample, no rd; expected count=4, full=1, overflow=1, entries 5'h10..5'h13. A second sample with joystick unchanged pushes nothing. ovf_clr then drives overflow=0.
REQ-041 Full with pop: FIFO full, rd held high during a scan that finds 2 changes; expected both events accepted, count stays 4, overflow stays 0.
REQ-042 Ignored sample and mid-scan reset: pulse sample on cycle 3 of a scan; expected scan length unchanged and no second scan. Then reset_n=0 on cycle 8 of a scan; expected all outputs at REQ-035 values one cycle later.
